// File: rtl/debug_bus_bridge.sv
// -----------------------------------------------------------------------------
// debug_bus_bridge
//
// Bridges NCH asynchronous debug requester channels onto a single CPU-domain
// system bus. Each channel raises a level request (CH_REQ) with a quasi-static
// payload. The bridge synchronises the request, arbitrates round-robin, and
// issues one bus access. It then answers with a 4-phase acknowledge
// (CH_ACK high until the request is withdrawn).
//
// Handshakes:
//   Channel side: CH_REQ rises -> bridge eventually raises CH_ACK with CH_DO /
//     CH_ERR valid -> requester drops CH_REQ -> bridge drops CH_ACK.
//     The payload (CH_WR/ST/AD/DI) must be stable while CH_REQ is high.
//   Bus side: PVALID high marks an outstanding request with PWR/PWSTB/PADDR/
//     PWDATA stable. It completes on the first cycle PREADY is high
//     (PRDATA/PERR sampled then), or after TIMEOUT cycles without PREADY
//     when TIMEOUT is non-zero.
//
// Ports:
//   CLK, RST_N            clock, synchronous active-low reset
//   CH_REQ/WR/ST/AD/DI    per-channel request and payload (flattened vectors)
//   CH_ACK/DO/ERR         per-channel acknowledge, read data, error status
//   PVALID/PWR/PWSTB/PADDR/PWDATA   system bus request
//   PREADY/PRDATA/PERR    system bus response
//   DBG_STATE             current FSM state (IDLE=0, BUS=1, ACKW=2)
// -----------------------------------------------------------------------------
module debug_bus_bridge #(
    parameter int NCH     = 3,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int SYNC    = 3,
    parameter int TIMEOUT = 255
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic [NCH-1:0]          CH_REQ,
    input  logic [NCH-1:0]          CH_WR,
    input  logic [NCH*(DW/8)-1:0]   CH_ST,
    input  logic [NCH*AW-1:0]       CH_AD,
    input  logic [NCH*DW-1:0]       CH_DI,
    output logic [NCH-1:0]          CH_ACK,
    output logic [NCH*DW-1:0]       CH_DO,
    output logic [NCH-1:0]          CH_ERR,
    output logic                    PVALID,
    output logic                    PWR,
    output logic [DW/8-1:0]         PWSTB,
    output logic [AW-1:0]           PADDR,
    output logic [DW-1:0]           PWDATA,
    input  logic                    PREADY,
    input  logic [DW-1:0]           PRDATA,
    input  logic                    PERR,
    output logic [1:0]              DBG_STATE
);

    localparam int SW = DW / 8;
    localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit TO_EN = (TIMEOUT != 0);
    // Counter value of the last BUS cycle allowed before the timeout fires.
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [GW-1:0] LAST_CH = GW'(NCH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_ACKW = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Synchroniser chains and edge detection
    logic [SYNC-1:0][NCH-1:0] sync_q;
    logic [NCH-1:0]           sreq;
    logic [NCH-1:0]           sreq_d;
    logic [NCH-1:0]           req_rise;
    logic [NCH-1:0]           req_fall;

    // Arbitration
    logic [NCH-1:0]           pending;
    logic [NCH-1:0]           pending_nxt;
    logic [GW-1:0]            last_grant;
    logic [GW-1:0]            grant_idx;
    logic                     grant_found;
    logic                     grant_fire;
    int                       cand;

    // Latched transaction
    logic [GW-1:0]            gnt_q;
    logic                     wr_q;
    logic [SW-1:0]            st_q;
    logic [AW-1:0]            ad_q;
    logic [DW-1:0]            di_q;
    logic                     sel_wr;
    logic [SW-1:0]            sel_st;
    logic [AW-1:0]            sel_ad;
    logic [DW-1:0]            sel_di;

    // Bus phase
    logic [CW-1:0]            cnt_q;
    logic                     bus_done;
    logic                     bus_to;
    logic                     ackw_done;

    // Response registers
    logic [NCH-1:0]           ack_q;
    logic [NCH-1:0]           err_q;
    logic [NCH-1:0][DW-1:0]   do_q;

    // -------------------------------------------------------------------------
    // Request synchronisers: only the last stage is ever used.
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            sync_q <= '0;
            sreq_d <= '0;
        end else begin
            sync_q[0] <= CH_REQ;
            for (int k = 1; k < SYNC; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
            sreq_d <= sreq;
        end
    end

    assign sreq     = sync_q[SYNC-1];
    assign req_rise = sreq & ~sreq_d;
    assign req_fall = ~sreq & sreq_d;

    // -------------------------------------------------------------------------
    // Round-robin pick: first pending channel after last_grant, wrapping.
    // -------------------------------------------------------------------------
    always_comb begin
        grant_idx   = last_grant;
        grant_found = 1'b0;
        cand        = 0;
        for (int k = 1; k <= NCH; k++) begin
            cand = int'(last_grant) + k;
            if (cand >= NCH) begin
                cand = cand - NCH;
            end
            if (!grant_found && pending[cand[GW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[GW-1:0];
            end
        end
    end

    assign grant_fire = (state_q == S_IDLE) && grant_found;

    // Payload of the channel being granted this cycle.
    always_comb begin
        sel_wr = CH_WR[grant_idx];
        sel_st = CH_ST[int'(grant_idx)*SW +: SW];
        sel_ad = CH_AD[int'(grant_idx)*AW +: AW];
        sel_di = CH_DI[int'(grant_idx)*DW +: DW];
    end

    // A falling sreq withdraws a request that has not been granted yet; the
    // channel being granted this cycle is removed from pending regardless.
    always_comb begin
        pending_nxt = (pending | req_rise) & ~req_fall;
        if (grant_fire) begin
            pending_nxt[grant_idx] = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Bus completion conditions
    // -------------------------------------------------------------------------
    assign bus_done  = (state_q == S_BUS) && PREADY;
    assign bus_to    = TO_EN && (state_q == S_BUS) && !PREADY && (cnt_q == TO_LAST);
    assign ackw_done = (state_q == S_ACKW) && !sreq[gnt_q];

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (grant_fire)          state_d = S_BUS;
            S_BUS:  if (bus_done || bus_to)  state_d = S_ACKW;
            S_ACKW: if (ackw_done)           state_d = S_IDLE;
            default:                         state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs. Bus fields are forced to zero outside BUS so the bus is
    // quiet when idle and after reset.
    // -------------------------------------------------------------------------
    always_comb begin
        PVALID = 1'b0;
        PWR    = 1'b0;
        PWSTB  = '0;
        PADDR  = '0;
        PWDATA = '0;
        if (state_q == S_BUS) begin
            PVALID = 1'b1;
            PWR    = wr_q;
            PADDR  = ad_q;
            if (wr_q) begin
                PWSTB  = st_q;
                PWDATA = di_q;
            end
        end
    end

    assign CH_ACK    = ack_q;
    assign CH_ERR    = err_q;
    assign CH_DO     = do_q;
    assign DBG_STATE = state_q;

    // -------------------------------------------------------------------------
    // Datapath: pending set, latched payload, timeout counter, responses.
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            pending    <= '0;
            last_grant <= LAST_CH;
            gnt_q      <= '0;
            wr_q       <= 1'b0;
            st_q       <= '0;
            ad_q       <= '0;
            di_q       <= '0;
            cnt_q      <= '0;
            ack_q      <= '0;
            err_q      <= '0;
            do_q       <= '0;
        end else begin
            pending <= pending_nxt;

            if (grant_fire) begin
                gnt_q      <= grant_idx;
                last_grant <= grant_idx;
                wr_q       <= sel_wr;
                st_q       <= sel_st;
                ad_q       <= sel_ad;
                di_q       <= sel_di;
            end

            // Counts cycles spent in BUS; restarts from zero for each access.
            if (state_q == S_BUS) begin
                cnt_q <= cnt_q + 1'b1;
            end else begin
                cnt_q <= '0;
            end

            if (bus_done) begin
                if (!wr_q) begin
                    do_q[gnt_q] <= PRDATA;
                end
                err_q[gnt_q] <= PERR;
                ack_q[gnt_q] <= 1'b1;
            end else if (bus_to) begin
                if (!wr_q) begin
                    do_q[gnt_q] <= '1;
                end
                err_q[gnt_q] <= 1'b1;
                ack_q[gnt_q] <= 1'b1;
            end

            if (ackw_done) begin
                ack_q[gnt_q] <= 1'b0;
                err_q[gnt_q] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_debug_bus_bridge.sv
// -----------------------------------------------------------------------------
// tb_debug_bus_bridge
//
// Directed bench for debug_bus_bridge (NCH=3, 32-bit, SYNC=3, TIMEOUT=4).
// Inputs are driven 1 ns after the rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_debug_bus_bridge;

    localparam int NCH     = 3;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int SW      = DW / 8;
    localparam int SYNC    = 3;
    localparam int TIMEOUT = 4;

    // ------------------------------------------------------------------ clock/reset
    logic                  CLK = 1'b0;
    logic                  RST_N = 1'b0;
    always #5 CLK = ~CLK;

    logic [NCH-1:0]        CH_REQ = '0;
    logic [NCH-1:0]        CH_WR  = '0;
    logic [NCH*SW-1:0]     CH_ST  = '0;
    logic [NCH*AW-1:0]     CH_AD  = '0;
    logic [NCH*DW-1:0]     CH_DI  = '0;
    logic [NCH-1:0]        CH_ACK;
    logic [NCH*DW-1:0]     CH_DO;
    logic [NCH-1:0]        CH_ERR;
    logic                  PVALID;
    logic                  PWR;
    logic [SW-1:0]         PWSTB;
    logic [AW-1:0]         PADDR;
    logic [DW-1:0]         PWDATA;
    logic                  PREADY = 1'b0;
    logic [DW-1:0]         PRDATA = '0;
    logic                  PERR   = 1'b0;
    logic [1:0]            DBG_STATE;

    debug_bus_bridge #(
        .NCH(NCH), .AW(AW), .DW(DW), .SYNC(SYNC), .TIMEOUT(TIMEOUT)
    ) dut (
        .CLK(CLK), .RST_N(RST_N),
        .CH_REQ(CH_REQ), .CH_WR(CH_WR), .CH_ST(CH_ST), .CH_AD(CH_AD), .CH_DI(CH_DI),
        .CH_ACK(CH_ACK), .CH_DO(CH_DO), .CH_ERR(CH_ERR),
        .PVALID(PVALID), .PWR(PWR), .PWSTB(PWSTB), .PADDR(PADDR), .PWDATA(PWDATA),
        .PREADY(PREADY), .PRDATA(PRDATA), .PERR(PERR),
        .DBG_STATE(DBG_STATE)
    );

    // ------------------------------------------------------------------ scoreboard
    int         n_vec = 0;
    int         n_err = 0;
    logic [1:0] exp_q[$];   // expected bus grant order (channel numbers)

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------ driver tasks
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_pvalid(input string tag);
        int cyc = 0;
        while (PVALID !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        check({tag, "_pvalid"}, 64'(PVALID), 64'd1);
    endtask

    task automatic wait_ack_clear(input string tag);
        int cyc = 0;
        while (CH_ACK !== '0 && cyc < 20) begin
            tick();
            cyc++;
        end
        check({tag, "_ack_clr"}, 64'(CH_ACK), 64'd0);
        check({tag, "_err_clr"}, 64'(CH_ERR), 64'd0);
    endtask

    // Serves the next expected read: channel ch uses address 0x1000+16*ch and
    // receives data 0xC0DE0000+ch; the requester then withdraws.
    task automatic serve_read(input string tag);
        logic [1:0] ch;
        int         c;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $error("FAIL %s_queue: observed empty, expected entry", tag);
            return;
        end
        ch = exp_q.pop_front();
        c  = int'(ch);
        wait_pvalid(tag);
        check({tag, "_addr"}, 64'(PADDR), 64'(32'h1000 + 32'(c) * 32'h10));
        check({tag, "_pwr"}, 64'(PWR), 64'd0);
        PREADY = 1'b1;
        PRDATA = 32'hC0DE_0000 + 32'(c);
        tick();
        PREADY = 1'b0;
        check({tag, "_ack"}, 64'(CH_ACK), 64'(3'b001 << c));
        check({tag, "_do"}, 64'(CH_DO[c*DW +: DW]), 64'(32'hC0DE_0000 + 32'(c)));
        CH_REQ[c] = 1'b0;
        wait_ack_clear(tag);
    endtask

    // ------------------------------------------------------------------ watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------ directed sequence
    initial begin
        int hi;
        int pv_seen;
        int ack_seen;

        // Reset state
        repeat (3) tick();
        check("rst_pvalid", 64'(PVALID), 64'd0);
        check("rst_ack", 64'(CH_ACK), 64'd0);
        check("rst_err", 64'(CH_ERR), 64'd0);
        check("rst_do", 64'(|CH_DO), 64'd0);
        check("rst_paddr", 64'(PADDR), 64'd0);
        check("rst_pwstb", 64'(PWSTB), 64'd0);
        check("rst_state", 64'(DBG_STATE), 64'd0);
        RST_N = 1'b1;
        tick();

        // Uncontended read on channel 0: PVALID at edge SYNC+2 = 5
        CH_AD[31:0] = 32'h100;
        CH_WR[0]    = 1'b0;
        CH_REQ[0]   = 1'b1;
        repeat (4) tick();
        check("rd_pvalid_edge4", 64'(PVALID), 64'd0);
        tick();
        check("rd_pvalid_edge5", 64'(PVALID), 64'd1);
        check("rd_paddr", 64'(PADDR), 64'h100);
        check("rd_pwr", 64'(PWR), 64'd0);
        check("rd_pwstb", 64'(PWSTB), 64'd0);
        PREADY = 1'b1;
        PRDATA = 32'h1234_5678;
        tick();
        PREADY = 1'b0;
        PRDATA = '0;
        check("rd_ack", 64'(CH_ACK), 64'b001);
        check("rd_do0", 64'(CH_DO[31:0]), 64'h1234_5678);
        check("rd_err", 64'(CH_ERR), 64'd0);
        check("rd_pvalid_drop", 64'(PVALID), 64'd0);
        CH_REQ[0] = 1'b0;
        wait_ack_clear("rd");

        // Write on channel 0 with two wait states and a bus error
        CH_WR[0]    = 1'b1;
        CH_ST[3:0]  = 4'h3;
        CH_DI[31:0] = 32'hA5A5_A5A5;
        CH_AD[31:0] = 32'h200;
        PRDATA      = 32'hDEAD_BEEF;
        CH_REQ[0]   = 1'b1;
        wait_pvalid("wr");
        for (int k = 0; k < 3; k++) begin
            check("wr_pwr", 64'(PWR), 64'd1);
            check("wr_pwstb", 64'(PWSTB), 64'h3);
            check("wr_pwdata", 64'(PWDATA), 64'hA5A5_A5A5);
            check("wr_paddr", 64'(PADDR), 64'h200);
            if (k == 2) begin
                PREADY = 1'b1;
                PERR   = 1'b1;
            end
            tick();
        end
        PREADY = 1'b0;
        PERR   = 1'b0;
        check("wr_ack", 64'(CH_ACK), 64'b001);
        check("wr_err", 64'(CH_ERR), 64'b001);
        check("wr_do0_kept", 64'(CH_DO[31:0]), 64'h1234_5678);
        check("wr_pvalid_drop", 64'(PVALID), 64'd0);
        CH_REQ[0] = 1'b0;
        CH_WR[0]  = 1'b0;
        wait_ack_clear("wr");

        // Timeout on channel 1 read: PVALID high exactly TIMEOUT cycles
        CH_AD[63:32] = 32'h300;
        CH_REQ[1]    = 1'b1;
        wait_pvalid("to");
        hi = 1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (PVALID) hi++;
            else break;
        end
        check("to_pvalid_cycles", 64'(hi), 64'd4);
        check("to_ack", 64'(CH_ACK), 64'b010);
        check("to_err", 64'(CH_ERR), 64'b010);
        check("to_do1", 64'(CH_DO[63:32]), 64'hFFFF_FFFF);
        CH_REQ[1] = 1'b0;
        wait_ack_clear("to");

        // Channel 1 pulses and withdraws while channel 0 holds the bridge
        CH_AD[31:0] = 32'h400;
        CH_REQ[0]   = 1'b1;
        wait_pvalid("wd");
        CH_REQ[1] = 1'b1;
        tick();
        tick();
        PREADY = 1'b1;
        PRDATA = 32'h44;
        tick();
        PREADY = 1'b0;
        check("wd_ack0", 64'(CH_ACK), 64'b001);
        repeat (3) tick();
        CH_REQ[1] = 1'b0;
        pv_seen  = 0;
        ack_seen = 0;
        repeat (12) begin
            tick();
            if (PVALID) pv_seen++;
        end
        check("wd_ack0_held", 64'(CH_ACK), 64'b001);
        CH_REQ[0] = 1'b0;
        wait_ack_clear("wd");
        repeat (10) begin
            tick();
            if (PVALID) pv_seen++;
            if (CH_ACK != '0) ack_seen++;
        end
        check("wd_no_bus", 64'(pv_seen), 64'd0);
        check("wd_no_ack", 64'(ack_seen), 64'd0);

        // Reset during BUS, then a fresh request completes
        CH_AD[95:64] = 32'h500;
        CH_REQ[2]    = 1'b1;
        wait_pvalid("mr");
        RST_N = 1'b0;
        tick();
        check("mr_pvalid", 64'(PVALID), 64'd0);
        check("mr_ack", 64'(CH_ACK), 64'd0);
        check("mr_err", 64'(CH_ERR), 64'd0);
        check("mr_do", 64'(|CH_DO), 64'd0);
        check("mr_paddr", 64'(PADDR), 64'd0);
        CH_REQ[2] = 1'b0;
        tick();
        RST_N = 1'b1;
        tick();
        CH_AD[95:64] = 32'h600;
        CH_REQ[2]    = 1'b1;
        wait_pvalid("mr2");
        check("mr2_paddr", 64'(PADDR), 64'h600);
        PREADY = 1'b1;
        PRDATA = 32'h600D_F00D;
        tick();
        PREADY = 1'b0;
        check("mr2_ack", 64'(CH_ACK), 64'b100);
        check("mr2_do2", 64'(CH_DO[95:64]), 64'h600D_F00D);
        check("mr2_err", 64'(CH_ERR), 64'd0);
        CH_REQ[2] = 1'b0;
        wait_ack_clear("mr2");

        // Round robin: all three together after channel 2 -> 0,1,2
        for (int i = 0; i < NCH; i++) begin
            CH_AD[i*AW +: AW] = 32'h1000 + 32'(i) * 32'h10;
        end
        CH_WR  = '0;
        CH_REQ = 3'b111;
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd2);
        serve_read("rr_a0");
        serve_read("rr_a1");
        serve_read("rr_a2");

        // Then 2 and 0 together after channel 2 -> 0 before 2
        CH_REQ[2] = 1'b1;
        CH_REQ[0] = 1'b1;
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd2);
        serve_read("rr_b0");
        serve_read("rr_b1");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/debug_bus_bridge.md
DEBUG_BUS_BRIDGE -- requirements
Module: debug_bus_bridge

Interface
REQ-001 Parameter NCH, default 3, number of debug requester channels (1..8).
REQ-002 Parameter AW, default 32, address width.
REQ-003 Parameter DW, default 32, data width; byte strobe width SW = DW/8.
REQ-004 Parameter SYNC, default 3, synchroniser depth on each CH_REQ bit (minimum 2).
REQ-005 Parameter TIMEOUT, default 255, bus wait limit in cycles; 0 disables timeout.
REQ-006 CLK  in  1  CPU-domain clock; RST_N  in  1  reset, synchronous, active-low.
REQ-007 CH_REQ  in  NCH  per-channel level request from debug domain, asynchronous to CLK.
REQ-008 CH_WR  in  NCH  per-channel write flag (1 = write).
REQ-009 CH_ST  in  NCH*SW  per-channel write byte strobes.
REQ-010 CH_AD  in  NCH*AW  per-channel address.
REQ-011 CH_DI  in  NCH*DW  per-channel write data.
REQ-012 CH_ACK  out  NCH  per-channel completion acknowledge (4-phase handshake).
REQ-013 CH_DO  out  NCH*DW  per-channel read data.
REQ-014 CH_ERR  out  NCH  per-channel error status, valid while CH_ACK is high.
REQ-015 PVALID  out  1; PWR  out  1; PWSTB  out  SW; PADDR  out  AW; PWDATA  out  DW: system bus request.
REQ-016 PREADY  in  1; PRDATA  in  DW; PERR  in  1: system bus response.

Function
REQ-017 Each CH_REQ bit passes through a SYNC-flop chain; only the last stage is used internally (sreq).
REQ-018 A rising edge of sreq[i] sets pending[i]; CH_WR/ST/AD/DI are quasi-static while CH_REQ is high and are sampled only at grant.
REQ-019 FSM states: IDLE, BUS, ACKW.
REQ-020 IDLE: when any pending, grant is the first pending channel searching from last_grant+1, wrapping at NCH; payload latched, pending[grant] cleared, last_grant updated, go to BUS.
REQ-021 Latency: an uncontended request drives PVALID high exactly SYNC+2 CLK edges after the first edge sampling CH_REQ high.
REQ-022 BUS: PVALID=1; PWR, PADDR, PWDATA held stable; PWSTB = latched strobes for writes, 0 for reads; timeout counter increments each cycle.
REQ-023 BUS completion on PREADY=1: read latches PRDATA into CH_DO[grant], write leaves CH_DO unchanged; CH_ERR[grant] = PERR; CH_ACK[grant] set; PVALID drops next cycle; go to ACKW.
REQ-024 BUS timeout (TIMEOUT!=0) when the counter reaches TIMEOUT with PREADY low: PVALID drops, CH_ERR[grant]=1, read CH_DO[grant] = all-ones, CH_ACK[grant] set, go to ACKW.
REQ-025 ACKW: CH_ACK[grant] held until sreq[grant]=0, then CH_ACK and CH_ERR for that channel cleared and FSM returns to IDLE in the same cycle.
REQ-026 Withdrawal: sreq[i] falling while pending[i] and not granted clears pending[i]; no bus cycle, no ACK.
REQ-027 Withdrawal during BUS does not abort; transaction completes, ACK asserts one cycle and clears in ACKW.
REQ-028 Simultaneous pending edges are all recorded; served one per transaction in round-robin order; no channel starves.
REQ-029 New rising edge on a channel in ACKW is impossible by protocol; if sreq stays high, no re-request until it falls and rises again.
REQ-030 Only one CH_ACK bit high at any time; bus accesses never overlap.

Reset
REQ-031 RST_N low: FSM=IDLE, sync chains, pending, counter = 0, last_grant = NCH-1, all outputs 0 including CH_DO.
REQ-032 Reset mid-transaction aborts immediately; PVALID low at the first edge with RST_N low; no ACK issued.

Verification
REQ-033 SYNC=3, CH_REQ[0] read AD=0x100, PREADY high on first PVALID cycle, PRDATA=0x12345678 -> PVALID at edge 5, CH_DO[0]=0x12345678, CH_ACK[0]=1, CH_ERR[0]=0.
REQ-034 Write ST=0x3, DI=0xA5A5A5A5 -> PWSTB=0x3, PWDATA=0xA5A5A5A5, PWR=1 for whole BUS; CH_DO[0] unchanged.
REQ-035 CH_REQ[0..2] raised same cycle -> bus order 0,1,2; then 2 and 0 raised together -> 0 before 2.
REQ-036 TIMEOUT=4, PREADY held low -> PVALID high 4 cycles, CH_ERR=1, CH_DO=0xFFFFFFFF, ACK asserted.
REQ-037 CH_REQ[1] pulsed while channel 0 in BUS, dropped before grant -> no bus cycle for channel 1.
REQ-038 RST_N low during BUS -> all outputs 0 next edge; new request afterwards completes normally.
